count_enable_ctrl: RTL and testbench
====================================

// Module: count_enable_ctrl
// PURPOSE
//   Upstream control stage for the 4-bit JK synchronous counter.
//   Generates the counter's single-cycle enable pulse from a programmable prescaler, and provides start/stop/hold control.
//   Keeps a shadow copy of the count the counter should hold, and flags each wrap-around.
//   Sits between the bench/top-level control and the counter's en input.
// PARAMETERS
//   PRESCALE_W  8  width of divide value and prescaler register
//   CNT_W       4  width of shadow count; must match the downstream counter width
// PORTS
//   clk       in   1           rising-edge clock, shared with the downstream counter
//   rst_n     in   1           asynchronous reset, active low
//   start     in   1           level; sampled in IDLE, begins a run
//   stop      in   1           level; abort to IDLE, highest priority
//   hold      in   1           level; freezes the run while high
//   div       in   PRESCALE_W  divide ratio D; latched on start accept
//   en        out  1           enable to the counter; high one cycle per D run cycles
//   tick_cnt  out  CNT_W       shadow count; number of en pulses mod 2^CNT_W
//   wrap      out  1           high in the same cycle as the en pulse that takes tick_cnt from all-ones to 0
//   running   out  1           high in RUN or PAUSE
// BEHAVIOUR
//   - Reset (rst_n=0, asynchronous, also mid-run):
//       - State goes to IDLE immediately.
//       - Prescaler=0, div_q=1, tick_cnt=0.
//       - en=0, wrap=0, running=0.
//   - All outputs are registered.
//   - States and transitions:
//       - IDLE -> RUN on start=1 && stop=0. div_q<=(div==0)?1:div; prescaler<=0.
//       - RUN -> PAUSE on hold=1 && stop=0. Prescaler frozen; en=0.
//       - PAUSE -> RUN on hold=0. Prescaler resumes from its frozen value.
//       - RUN/PAUSE -> IDLE on stop=1 at any edge. Prescaler cleared; en=0 next cycle.
//       - Priority: stop > hold > start. start is ignored outside IDLE.
//   - Prescaler, in RUN only:
//       - Counts 0..div_q-1 and wraps to 0.
//       - At the edge where the prescaler equals div_q-1, en is registered high for the following cycle.
//       - If start is accepted at edge t0, the first en-high cycle follows edge t0+D. After that, en is high once every D RUN cycles.
//       - D=1 gives en continuously high in RUN.
//       - D=0 is treated as D=1.
//   - div is sampled only on start accept. Changing div mid-run has no effect.
//   - tick_cnt increments at the same edge that raises en, so it leads the counter by at most one cycle. It wraps modulo 2^CNT_W.
//   - wrap is high exactly when the en pulse takes tick_cnt from 2^CNT_W-1 to 0.
//   - tick_cnt is not cleared by stop; only rst_n clears it. The downstream counter has no reset, so the shadow keeps tracking it.
//   - hold and stop together: stop wins, next state IDLE.
//   - hold asserted on the same edge an en would be raised: en suppressed, prescaler holds at div_q-1, and the pulse fires on the first RUN edge after release.
// CONFIGURATION
//   CNT_CTRL_ONESHOT_EN defined:
//     - After the en pulse that raises wrap, the FSM goes to IDLE on the next edge (running=0).
//     - Each run therefore delivers exactly 2^CNT_W pulses; a new start is required.
//   CNT_CTRL_ONESHOT_EN undefined:
//     - Free-running; tick_cnt wraps indefinitely until stop.
// TESTING
//   1. Reset mid-run (rst_n low between edges during a RUN):
//      - Expect en=0, tick_cnt=0, running=0 with no clock edge.
//      - Then start with div=3: first en 3 cycles after start accept.
//   2. div=4, start for one cycle, 40 cycles:
//      - en high exactly 1 of every 4 cycles.
//      - tick_cnt walks 0..10; counter Q equals tick_cnt one cycle after each pulse.
//   3. div=1, run 20 cycles:
//      - en constantly high; wrap high once, at the 16th pulse; tick_cnt=4 at end.
//   4. div=5; assert hold after 2 cycles of RUN for 7 cycles, then release:
//      - No en while held; next en 3 cycles after release.
//      - Then assert stop+hold together: IDLE, running=0.
//   5. div=0, start; stop after 6 pulses:
//      - Behaves as div=1.
//      - After stop, tick_cnt stays 6; a restart continues from 6.
//      - Changing div during RUN does not change the period.
//   6. CNT_CTRL_ONESHOT_EN defined, div=2:
//      - Exactly 16 en pulses; wrap on the 16th; running=0 next cycle.
//      - No further en until start.
//      - Undefined: pulses continue past 16.

Source files
------------

// File: rtl/count_enable_ctrl.sv
// Enable-pulse generator for the 4-bit JK counter: programmable prescaler, start/stop/hold
// control and a shadow tick count. Define CNT_CTRL_ONESHOT_EN for one-shot (2^CNT_W pulse) runs.
module count_enable_ctrl #(
  parameter int PRESCALE_W = 8,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  hold,
  input  logic [PRESCALE_W-1:0] div,
  output logic                  en,
  output logic [CNT_W-1:0]      tick_cnt,
  output logic                  wrap,
  output logic                  running,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_e;

  localparam logic [PRESCALE_W-1:0] PRESC_ONE = PRESCALE_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);

  state_e                  state_q, state_d;
  logic [PRESCALE_W-1:0]   presc_q, presc_d;
  logic [PRESCALE_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]        tick_q, tick_d;
  logic                    en_q, en_d;
  logic                    wrap_q, wrap_d;
  logic                    running_q, running_d;
  logic                    presc_last;
  logic                    oneshot_done;

  assign presc_last = (presc_q == (div_q - PRESC_ONE));

`ifdef CNT_CTRL_ONESHOT_EN
  // The cycle carrying the wrapping pulse ends the run.
  assign oneshot_done = wrap_q;
`else
  assign oneshot_done = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    div_d   = div_q;
    tick_d  = tick_q;
    en_d    = 1'b0;
    wrap_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_RUN;
          div_d   = (div == '0) ? PRESC_ONE : div;
          presc_d = '0;
        end
      end
      S_RUN: begin
        if (stop || oneshot_done) begin
          state_d = S_IDLE;
          presc_d = '0;
        end else if (hold) begin
          // Freezing here also suppresses a pulse due on this edge; it fires after release.
          state_d = S_PAUSE;
        end else if (presc_last) begin
          presc_d = '0;
          en_d    = 1'b1;
          tick_d  = tick_q + CNT_ONE;
          wrap_d  = (tick_q == '1);
        end else begin
          presc_d = presc_q + PRESC_ONE;
        end
      end
      S_PAUSE: begin
        if (stop) begin
          state_d = S_IDLE;
          presc_d = '0;
        end else if (!hold) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
        presc_d = '0;
      end
    endcase
    running_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      div_q     <= PRESC_ONE;
      tick_q    <= '0;
      en_q      <= 1'b0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      en_q      <= en_d;
      wrap_q    <= wrap_d;
      running_q <= running_d;
    end
  end

  assign en        = en_q;
  assign tick_cnt  = tick_q;
  assign wrap      = wrap_q;
  assign running   = running_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_count_enable_ctrl.sv
// Directed bench for count_enable_ctrl: a countdown reference model feeds an expected queue,
// popped and compared one step after each clock edge.
module tb_count_enable_ctrl;

`ifdef CNT_CTRL_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       hold;
  logic [7:0] div;
  logic       en;
  logic [3:0] tick_cnt;
  logic       wrap;
  logic       running;
  logic [1:0] dbg_state;

  int n_vec;
  int n_err;
  int en_seen;
  int wrap_seen;

  // reference model state: 0 idle, 1 run, 2 pause; m_rem = run edges left until the pulse edge
  int         m_st;
  int         m_rem;
  int         m_div;
  logic [3:0] m_tick;
  logic       m_en;
  logic       m_wrap;

  logic [6:0] exp_q[$];

  count_enable_ctrl #(.PRESCALE_W(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .hold      (hold),
    .div       (div),
    .en        (en),
    .tick_cnt  (tick_cnt),
    .wrap      (wrap),
    .running   (running),
    .dbg_state (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_st   = 0;
    m_rem  = 1;
    m_div  = 1;
    m_tick = 4'd0;
    m_en   = 1'b0;
    m_wrap = 1'b0;
  endtask

  task automatic model_edge();
    logic pulse;
    pulse = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    case (m_st)
      0: if (start && !stop) begin
        m_st  = 1;
        m_div = (div == 8'd0) ? 1 : int'(div);
        m_rem = m_div;
      end
      1: begin
        if (stop) m_st = 0;
        else if (ONESHOT && m_wrap) m_st = 0;
        else if (hold) m_st = 2;
        else if (m_rem == 1) begin
          pulse = 1'b1;
          m_rem = m_div;
        end else m_rem = m_rem - 1;
      end
      default: begin
        if (stop) m_st = 0;
        else if (!hold) m_st = 1;
      end
    endcase
    m_wrap = pulse && (m_tick == 4'hf);
    if (pulse) m_tick = m_tick + 4'd1;
    m_en = pulse;
  endtask

  task automatic step();
    logic [6:0] e;
    @(posedge clk);
    model_edge();
    exp_q.push_back({(m_st != 0), m_en, m_wrap, m_tick});
    #1;
    e = exp_q.pop_front();
    chk("running", running, e[6]);
    chk("en", en, e[5]);
    chk("wrap", wrap, e[4]);
    chk("tick_cnt", tick_cnt, e[3:0]);
    if (en) en_seen++;
    if (wrap) wrap_seen++;
  endtask

  task automatic do_reset();
    start = 1'b0;
    stop  = 1'b0;
    hold  = 1'b0;
    rst_n = 1'b0;
    #2;
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    hold  = 1'b0;
    div   = 8'd1;
    model_reset();
    step();
    step();
    chk("rst_state", dbg_state, 0);
    rst_n = 1'b1;

    // 1: reset mid-run, then div=3 first-pulse latency
    div = 8'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("t1_async_en", en, 0);
    chk("t1_async_tick", tick_cnt, 0);
    chk("t1_async_running", running, 0);
    chk("t1_async_wrap", wrap, 0);
    chk("t1_async_state", dbg_state, 0);
    model_reset();
    step();
    rst_n = 1'b1;
    div = 8'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("t1_no_early_en", en, 0);
    step();
    chk("t1_first_en", en, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // 2: div=4 for 40 cycles
    do_reset();
    div = 8'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    en_seen = 0;
    repeat (40) step();
    chk("t2_pulses", en_seen, 10);
    chk("t2_tick", tick_cnt, 10);

    // 3: div=1 for 20 cycles
    do_reset();
    div = 8'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    en_seen = 0;
    wrap_seen = 0;
    repeat (20) step();
    chk("t3_pulses", en_seen, ONESHOT ? 16 : 20);
    chk("t3_wraps", wrap_seen, 1);
    chk("t3_tick", tick_cnt, ONESHOT ? 0 : 4);

    // 4: div=5 with hold, then stop+hold together
    do_reset();
    div = 8'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    hold = 1'b1;
    en_seen = 0;
    repeat (7) step();
    chk("t4_en_while_held", en_seen, 0);
    chk("t4_paused_running", running, 1);
    hold = 1'b0;
    step();
    n = 0;
    en_seen = 0;
    while (en_seen == 0 && n < 12) begin
      step();
      n++;
    end
    chk("t4_release_latency", n, 3);
    stop = 1'b1;
    hold = 1'b1;
    step();
    chk("t4_stop_hold_running", running, 0);
    stop = 1'b0;
    hold = 1'b0;
    step();

    // 5: div=0 acts as div=1; stop keeps tick_cnt; restart continues
    do_reset();
    div = 8'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    div = 8'd7;
    n = 0;
    en_seen = 0;
    while (en_seen < 6 && n < 20) begin
      step();
      n++;
    end
    chk("t5_steps_for_6", n, 6);
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (4) step();
    chk("t5_tick_after_stop", tick_cnt, 6);
    div = 8'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("t5_tick_restart", tick_cnt, 7);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // 6: div=2 for 40 cycles; one-shot stops after 16 pulses
    do_reset();
    div = 8'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    en_seen = 0;
    wrap_seen = 0;
    repeat (40) step();
    chk("t6_pulses", en_seen, ONESHOT ? 16 : 20);
    chk("t6_wraps", wrap_seen, 1);
    chk("t6_running", running, ONESHOT ? 0 : 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
